// File: rtl/rstseq_pkg.sv
// Shared types for the CLKDIV reset/enable sequencer.
// Optional status ports: ZED_RSTSEQ_STATUS_EN.
package rstseq_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    S_WAIT_LOCK   = 3'd0,
    S_LOCK_STABLE = 3'd1,
    S_DIV_RESET   = 3'd2,
    S_DIV_RUN     = 3'd3,
    S_READY       = 3'd4
  } state_t;

endpackage

// File: rtl/clkdiv_rst_seq_sync2.sv
// Two-flop synchroniser with async active-low clear.
// Used to bring pll_lock into the hclkin domain.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clkdiv_rst_seq.sv
// Reset/enable sequencer upstream of the divide-by-4 CLKDIV.
// Define ZED_RSTSEQ_STATUS_EN for lock_loss_cnt/seq_state.
module clkdiv_rst_seq
  import rstseq_pkg::*;
#(
  parameter int LOCK_CYCLES   = 1024,
  parameter int DIVRST_CYCLES = 16,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic       hclkin,
  input  logic       resetn,
  input  logic       pll_lock,
  output logic       clkdiv_resetn,
  output logic       sys_resetn,
`ifdef ZED_RSTSEQ_STATUS_EN
  output logic [7:0] lock_loss_cnt,
  output logic [2:0] seq_state,
`endif
  output logic       ready
);

  localparam logic [CNT_W-1:0] LOCK_TC =
    CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIVRST_TC =
    CNT_W'(DIVRST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_TC =
    CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             lock_s;
  logic             div_nxt;
  logic             sys_nxt;

  sync2 u_lock_sync (
    .clk   (hclkin),
    .rst_n (resetn),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Next-state, shared counter and next-output decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    unique case (state)
      S_WAIT_LOCK: begin
        cnt_nxt = '0;
        if (lock_s) state_nxt = S_LOCK_STABLE;
      end
      S_LOCK_STABLE: begin
        if (!lock_s)            state_nxt = S_WAIT_LOCK;
        else if (cnt == LOCK_TC) state_nxt = S_DIV_RESET;
      end
      S_DIV_RESET: begin
        if (!lock_s)              state_nxt = S_WAIT_LOCK;
        else if (cnt == DIVRST_TC) state_nxt = S_DIV_RUN;
      end
      S_DIV_RUN: begin
        if (!lock_s)              state_nxt = S_WAIT_LOCK;
        else if (cnt == SETTLE_TC) state_nxt = S_READY;
      end
      S_READY: begin
        cnt_nxt = '0;
        if (!lock_s) state_nxt = S_WAIT_LOCK;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = S_WAIT_LOCK;
      end
    endcase
    if (state_nxt != state) cnt_nxt = '0;
    div_nxt = (state_nxt == S_DIV_RUN) ||
              (state_nxt == S_READY);
    sys_nxt = (state_nxt == S_READY);
  end

  // State, counter and registered outputs
  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) begin
      state         <= S_WAIT_LOCK;
      cnt           <= '0;
      clkdiv_resetn <= 1'b0;
      sys_resetn    <= 1'b0;
      ready         <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      clkdiv_resetn <= div_nxt;
      sys_resetn    <= sys_nxt;
      ready         <= sys_nxt;
    end
  end

`ifdef ZED_RSTSEQ_STATUS_EN
  assign seq_state = state;

  // Saturating count of lock losses seen while ready
  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) begin
      lock_loss_cnt <= 8'd0;
    end else if (state == S_READY && !lock_s &&
                 lock_loss_cnt != 8'hFF) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
`endif

endmodule
